// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
//            state_e   - loader state encoding
//            NOP_WORD  - RV32I "addi x0,x0,0" used to pad unused words
//            HDR_BYTES - length of the little-endian word-count header
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        CLEAR = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam int          HDR_BYTES = 2;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
// Module   : word_packer
// Purpose  : Packs a little-endian byte stream into 32-bit words. The first
//            byte of each group of four lands in bits 7:0. word_valid pulses
//            combinationally with the fourth byte so the caller can register
//            the word on the same edge the byte is accepted.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            clr        - synchronous clear of the byte counter
//            byte_en    - byte_data is consumed this cycle
//            byte_data  - stream byte
//            word_valid - fourth byte of a word is being consumed
//            word       - assembled word, valid with word_valid
// Revision : 1.0 - initial release
// ============================================================================
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    // Only the three earlier bytes need storage; the fourth is taken directly
    // from the input when the word completes.
    logic [23:0] shreg_q, shreg_d;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (byte_en) begin
            cnt_d   = cnt_q + 2'd1;
            shreg_d = {byte_data, shreg_q[23:8]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 2'd0;
            shreg_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_valid = byte_en && (cnt_q == 2'd3);
    assign word       = {byte_data, shreg_q};

endmodule : word_packer
`default_nettype wire

// File: rtl/imem_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_ctrl
// Purpose  : Loads a program image from a byte stream into instruction memory.
//            Image = 16-bit LE word count N, then N LE 32-bit words. Words
//            above N are filled with NOPs. The core is held in reset (and
//            fetch stalled) for the whole load and released once done.
// Ports    : clk, rst (async, active low)
//            start_load                      - begin a load (IDLE/DONE/ERR)
//            byte_valid, byte_data, byte_ready - byte stream handshake
//            imem_we, imem_waddr, imem_wdata - instruction memory write port
//            core_rst, StallF                - core hold / fetch stall
//            busy, done, err                 - load status
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_ctrl #(
    parameter int WordQuantity = 256,
    parameter int BitSize      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_load,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [BitSize-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               core_rst,
    output logic               StallF,
    output logic               busy,
    output logic               done,
    output logic               err
);
    import imem_loader_pkg::*;

    localparam int                 NW       = 8 * HDR_BYTES;
    // One spare bit so a count of WordQuantity is representable.
    localparam logic [NW:0]        WQ_EXT   = (NW+1)'(WordQuantity);
    localparam logic [BitSize:0]   LAST_IDX = (BitSize+1)'(WordQuantity - 1);

    state_e             state_q, state_d;
    logic [BitSize:0]   widx_q, widx_d;
    logic [NW-1:0]      n_q, n_d;
    logic               imem_we_q, imem_we_d;
    logic [BitSize-1:0] imem_waddr_q, imem_waddr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               core_rst_q, core_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               byte_fire;
    logic               start_acc;
    logic               word_valid;
    logic [31:0]        packed_word;
    logic [NW-1:0]      n_shift;
    logic [BitSize:0]   widx_inc;

    // Ready drops in DATA for the cycle a finished word is on the write port.
    assign byte_ready = (state_q == HDR0) || (state_q == HDR1) ||
                        ((state_q == DATA) && !imem_we_q);
    assign byte_fire  = byte_valid && byte_ready;

    // Header bytes arrive low byte first; shifting in from the top leaves the
    // full count right-aligned after the last header byte.
    assign n_shift  = {byte_data, n_q[NW-1:8]};
    assign widx_inc = widx_q + 1'b1;

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .byte_en    (byte_fire && (state_q == DATA)),
        .byte_data  (byte_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        n_d          = n_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        done_d       = done_q;
        err_d        = err_q;
        start_acc    = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                // Release lags the final write by one cycle.
                if (state_q == DONE) begin
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                end
                if (start_load) begin
                    state_d    = HDR0;
                    widx_d     = '0;
                    core_rst_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    start_acc  = 1'b1;
                end
            end
            HDR0: begin
                if (byte_fire) begin
                    n_d     = n_shift;
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (byte_fire) begin
                    n_d = n_shift;
                    if ({1'b0, n_shift} > WQ_EXT) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (n_shift == '0) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_waddr_d = widx_q[BitSize-1:0];
                    imem_wdata_d = packed_word;
                    widx_d       = widx_inc;
                    if (NW'(widx_inc) == n_q) begin
                        state_d = ({1'b0, n_q} < WQ_EXT) ? CLEAR : DONE;
                    end
                end
            end
            CLEAR: begin
                imem_we_d    = 1'b1;
                imem_waddr_d = widx_q[BitSize-1:0];
                imem_wdata_d = NOP_WORD;
                widx_d       = widx_inc;
                if (widx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == HDR0) || (state_d == HDR1) ||
                 (state_d == DATA) || (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            widx_q       <= '0;
            n_q          <= '0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= 32'd0;
            core_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            n_q          <= n_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign StallF     = core_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule : imem_loader_ctrl
`default_nettype wire

// File: tb/tb_imem_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader_ctrl
// Purpose  : Directed self-checking bench for imem_loader_ctrl. A behavioural
//            instruction memory captures every write so final contents can be
//            compared against hand-computed images.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader_ctrl;
    import imem_loader_pkg::*;

    localparam int WQ = 256;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start_load = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data  = 8'd0;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        StallF;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    imem_loader_ctrl #(.WordQuantity(WQ), .BitSize(8)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .start_load (start_load),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .StallF     (StallF),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Behavioural instruction memory and traffic counters
    logic [31:0] mem [0:WQ-1];
    int          cyc        = 0;
    int          wr_cnt     = 0;
    int          acc_cnt    = 0;
    int          last_wcyc  = -1;
    logic [7:0]  last_waddr = 8'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (byte_valid && byte_ready) acc_cnt <= acc_cnt + 1;
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
            wr_cnt          <= wr_cnt + 1;
            last_wcyc       <= cyc;
            last_waddr      <= imem_waddr;
        end
    end

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] bq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic pulse_start();
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    // Called at a negedge; leaves byte_valid high for back-to-back streaming.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_fail++;
            $error("FAIL byte-timeout observed=%0h expected=ready", b);
        end
        @(negedge clk);
    endtask

    task automatic send_all(input bit gaps);
        for (int i = 0; i < bq.size(); i++) begin
            if (gaps) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (i == 5 || $urandom_range(0, 3) == 0) begin
                    pulse_start();
                    if (i == 5) begin
                        chk("ignored-start-busy", 32'(busy), 1);
                        chk("ignored-start-done", 32'(done), 0);
                    end
                end
            end
            send_byte(bq[i]);
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "-done"}, 32'(done), 1);
        chk({tag, "-corerst-stall"}, {30'd0, core_rst, StallF}, 0);
        chk({tag, "-last-addr"}, 32'(last_waddr), 255);
        chk({tag, "-release-timing"}, 32'(last_wcyc), 32'(cyc - 1));
    endtask

    task automatic nop_from(input string tag, input int from);
        int bad = 0;
        for (int i = from; i < WQ; i++) if (mem[i] !== NOP_WORD) bad++;
        chk({tag, "-nopfill"}, 32'(bad), 0);
    endtask

    initial begin
        int w0;
        int a0;
        int bad;
        logic [7:0] ib;

        // ---- Reset ----
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset-ctl", {25'd0, byte_ready, imem_we, core_rst, StallF, busy, done, err}, 0);
        chk("reset-addr", 32'(imem_waddr), 0);
        chk("reset-data", imem_wdata, 0);

        // ---- N=2 plus NOP fill ----
        pulse_start();
        chk("start-ctl", {28'd0, core_rst, StallF, busy, byte_ready}, 32'hF);
        w0 = wr_cnt;
        bq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        send_all(1'b0);
        wait_done("n2");
        chk("n2-writes", 32'(wr_cnt - w0), 256);
        chk("n2-word0", mem[0], 32'h0000_0093);
        chk("n2-word1", mem[1], 32'h0010_0113);
        nop_from("n2", 2);

        // ---- N=0: all NOP, no data bytes taken ----
        @(negedge clk);
        pulse_start();
        chk("n0-done-cleared", 32'(done), 0);
        w0 = wr_cnt;
        a0 = acc_cnt;
        bq = '{8'h00, 8'h00};
        send_all(1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        wait_done("n0");
        byte_valid = 1'b0;
        chk("n0-accepted", 32'(acc_cnt - a0), 2);
        chk("n0-writes", 32'(wr_cnt - w0), 256);
        nop_from("n0", 0);

        // ---- N=257: rejected ----
        pulse_start();
        w0 = wr_cnt;
        a0 = acc_cnt;
        bq = '{8'h01, 8'h01};
        send_all(1'b0);
        chk("n257-flags", {27'd0, err, core_rst, byte_ready, busy, done}, 32'b11000);
        byte_valid = 1'b1;
        repeat (10) @(negedge clk);
        byte_valid = 1'b0;
        chk("n257-no-writes", 32'(wr_cnt - w0), 0);
        chk("n257-accepted", 32'(acc_cnt - a0), 2);
        chk("n257-err-sticky", 32'(err), 1);
        pulse_start();
        chk("restart-from-err", {30'd0, err, busy}, 32'b01);

        // ---- N=2 again with gaps and stray start pulses ----
        w0 = wr_cnt;
        bq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        send_all(1'b1);
        wait_done("gap");
        chk("gap-writes", 32'(wr_cnt - w0), 256);
        chk("gap-word0", mem[0], 32'h0000_0093);
        chk("gap-word1", mem[1], 32'h0010_0113);
        nop_from("gap", 2);

        // ---- N=256: full image, no CLEAR phase ----
        @(negedge clk);
        pulse_start();
        w0 = wr_cnt;
        bq = '{8'h00, 8'h01};
        for (int i = 0; i < WQ; i++) begin
            ib = 8'(i);
            bq.push_back(ib);
            bq.push_back(~ib);
            bq.push_back(8'hA5);
            bq.push_back(ib ^ 8'h3C);
        end
        send_all(1'b0);
        wait_done("n256");
        chk("n256-writes", 32'(wr_cnt - w0), 256);
        chk("n256-word255", mem[255], 32'hC3A5_00FF);
        bad = 0;
        for (int i = 0; i < WQ; i++) begin
            ib = 8'(i);
            if (mem[i] !== {ib ^ 8'h3C, 8'hA5, ~ib, ib}) bad++;
        end
        chk("n256-image", 32'(bad), 0);

        // ---- Reset in the middle of word 1 ----
        @(negedge clk);
        pulse_start();
        bq = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_all(1'b0);
        w0 = wr_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst-ctl", {25'd0, byte_ready, imem_we, core_rst, StallF, busy, done, err}, 0);
        chk("midrst-partial-word0", mem[0], 32'h4433_2211);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst-no-writes", 32'(wr_cnt - w0), 0);
        chk("midrst-idle", {30'd0, busy, core_rst}, 0);

        // ---- Reload N=1 ----
        pulse_start();
        w0 = wr_cnt;
        bq = '{8'h01, 8'h00, 8'h37, 8'h05, 8'h00, 8'h00};
        send_all(1'b0);
        wait_done("n1");
        chk("n1-writes", 32'(wr_cnt - w0), 256);
        chk("n1-word0", mem[0], 32'h0000_0537);
        nop_from("n1", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_imem_loader_ctrl
`default_nettype wire

// File: doc/imem_loader_ctrl.md
# imem_loader_ctrl

Program-load controller for the fetch stage's instruction memory. It accepts a byte stream carrying a program image, packs it into 32-bit words, and drives the instruction memory write port. While loading it holds the core in reset and stalls fetch; it fills unused words with NOPs, then releases the core so execution starts at PC 0. It sits between an external byte source (UART/debug bridge) and the Instruction Fetch stage / instruction memory.

## Interface
Parameters:
- WordQuantity, 256, instruction memory depth in 32-bit words
- BitSize, 8, word-index width; WordQuantity = 2**BitSize

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- start_load  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR
- byte_valid  in  1  byte_data valid
- byte_data  in  8  stream byte
- byte_ready  out  1  controller accepts a byte this cycle
- imem_we  out  1  instruction memory write enable
- imem_waddr  out  BitSize  word index written
- imem_wdata  out  32  word written
- core_rst  out  1  holds the pipeline and PC in reset (PC=0)
- StallF  out  1  fetch stall, equal to core_rst
- busy  out  1  load in progress (HDR0..CLEAR)
- done  out  1  sticky: last load completed
- err  out  1  sticky: last load rejected

## Operation
- Image format: 2-byte little-endian word count N, then 4·N bytes, each word little-endian (first byte = bits 7:0).
- A byte transfers on a cycle where byte_valid && byte_ready.
- States:
  - IDLE: outputs idle. start_load -> HDR0.
  - HDR0: accept the low byte of N -> HDR1.
  - HDR1: accept the high byte of N. If N > WordQuantity -> ERR. If N = 0 -> CLEAR. Otherwise -> DATA.
  - DATA: accept bytes. Every 4th byte, write the packed word at index widx and increment widx. After word N-1 is written: -> CLEAR if N < WordQuantity, else -> DONE.
  - CLEAR: no bytes accepted. Write NOP 32'h00000013 at widx, one word per cycle, until index WordQuantity-1 is written -> DONE.
  - DONE: core_rst=0, done=1. start_load -> HDR0.
  - ERR: err=1, core_rst stays 1, byte_ready=0. start_load -> HDR0 (clears err). No other exit except rst.
- byte_ready=1 only in HDR0, HDR1 and DATA. In DATA it is forced to 0 during the cycle the completed word is written.
- widx clears to 0 on entry to HDR0.
- start_load while busy is ignored. done and err clear on an accepted start_load.
- Reset mid-load: all state returns to IDLE and core_rst drops. Memory keeps the partial image; software must reload.

## Timing
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst=0, StallF=0, busy=0, done=0, err=0.
- All outputs are registered. byte_ready is decoded from the registered state.
- start_load at edge k: core_rst, StallF, busy and byte_ready are all 1 after edge k.
- Word write: the 4th byte accepted at edge k gives imem_we=1 with address and data valid during cycle k..k+1. The write commits at edge k+1.
- CLEAR takes exactly WordQuantity-N cycles of imem_we=1.
- core_rst falls the cycle after the final write (DATA or CLEAR); done rises the same cycle.
- Width rules:
  - N is 16 bits and is compared against WordQuantity at 17-bit width.
  - widx is BitSize+1 bits internally, so widx = WordQuantity is representable; imem_waddr takes the low BitSize bits.

## Structure
- Package imem_loader_pkg holds:
  - state enum: IDLE, HDR0, HDR1, DATA, CLEAR, DONE, ERR
  - NOP_WORD = 32'h00000013
  - HDR_BYTES = 2
- Sub-module word_packer: 2-bit byte counter plus 32-bit shift assembly. It emits word_valid for one cycle together with the word. Cleared on HDR0 entry.

## Test plan
- Reset: hold rst=0, then release → all outputs 0, state IDLE, core_rst=0.
- Load N=2, bytes 02 00 | 93 00 00 00 | 13 01 10 00 → writes 0x00000093@0 and 0x00100113@1, then 254 NOP writes @2..255; core_rst falls 1 cycle after the @255 write; done=1.
- N=0 (bytes 00 00) → 256 consecutive NOP writes, no DATA bytes accepted, then done=1.
- N=257 (bytes 01 01) → err=1, core_rst stays 1, byte_ready=0, no imem_we. A new start_load clears err.
- Random byte_valid gaps and start_load pulses mid-load → identical memory contents; start_load ignored while busy.
- Assert rst=0 in the middle of DATA word 1 → next cycle IDLE, core_rst=0, no further imem_we. Reload with N=1 → correct word@0 and NOP fill.
